// File: rtl/one_to_four_demux_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : one_to_four_demux_buf_pkg
//  Purpose  : Shared constants, channel index enum and the SEL decode helper
//             for the 1-to-4 demux buffer and the matching 4-to-1 select mux.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package one_to_four_demux_buf_pkg;

    // Number of consumer channels and the width of the select field.
    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    // Channel index: value of SEL that addresses each consumer.
    typedef enum logic [SEL_W-1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_C = 2'd2,
        CH_D = 2'd3
    } ch_idx_e;

    // Full binary-to-one-hot decode of SEL. Every 2-bit code maps to a
    // channel, so there is no illegal value to trap.
    function automatic logic [NUM_OUT-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_OUT-1:0] onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage : one_to_four_demux_buf_pkg
`default_nettype wire

// File: rtl/one_to_four_demux_buf_demux_slot.sv
`default_nettype none
// ============================================================================
//  Module   : demux_slot
//  Purpose  : One-entry holding register with valid/ready drain. Used once
//             per output channel of one_to_four_demux_buf.
//  Ports    : clk        rising-edge clock
//             rst        synchronous active-high reset
//             load       a beat is accepted into this slot this cycle
//             load_data  payload of the accepted beat
//             out_ready  consumer takes the held beat this cycle
//             valid      slot holds a beat
//             data       held payload (last value kept while !valid)
//  Revision : 1.0  initial release
// ============================================================================
module demux_slot #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // The parent only raises load when the slot is empty or draining this
    // cycle, so a load never overwrites a beat the consumer has not taken.
    // Load takes priority over drain: a simultaneous drain and fill keeps
    // valid high and swaps in the new payload with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && out_ready) begin
            valid <= 1'b0;
        end
    end

endmodule : demux_slot
`default_nettype wire

// File: rtl/one_to_four_demux_buf.sv
`default_nettype none
// ============================================================================
//  Module   : one_to_four_demux_buf
//  Purpose  : Registered 1-to-4 demultiplexer. One producer stream is steered
//             by SEL to one of four one-entry output slots, each with its own
//             valid/ready handshake, so a stalled consumer only blocks beats
//             addressed to it.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             IN_VALID/IN_READY        producer handshake
//             IN_DATA, SEL             beat payload and destination channel
//             A..D_VALID / A..D_READY  per-channel consumer handshake
//             A, B, C, D               per-channel payload
//             BUSY                     any slot holds a beat
//  Revision : 1.0  initial release
// ============================================================================
module one_to_four_demux_buf
    import one_to_four_demux_buf_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [SEL_W-1:0] SEL,

    output logic             A_VALID,
    output logic             B_VALID,
    output logic             C_VALID,
    output logic             D_VALID,
    input  logic             A_READY,
    input  logic             B_READY,
    input  logic             C_READY,
    input  logic             D_READY,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,

    output logic             BUSY
);

    logic [NUM_OUT-1:0] slot_valid;
    logic [NUM_OUT-1:0] slot_ready;
    logic [NUM_OUT-1:0] sel_onehot;
    logic [NUM_OUT-1:0] slot_load;
    logic [WIDTH-1:0]   slot_data [NUM_OUT];
    logic               accept;

    assign slot_ready = {D_READY, C_READY, B_READY, A_READY};
    assign sel_onehot = sel_decode(SEL);

    // Ready looks only at the addressed slot: it can take a beat when empty
    // or when its consumer drains it this same cycle. The path from the
    // selected *_READY to IN_READY is deliberately combinational so a full
    // slot being drained can refill without a bubble. IN_VALID is not used
    // here, which keeps the producer free of a valid->ready loop.
    assign IN_READY = !rst && (!slot_valid[SEL] || slot_ready[SEL]);
    assign accept   = IN_VALID && IN_READY;
    assign slot_load = accept ? sel_onehot : '0;

    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
            demux_slot #(
                .WIDTH     (WIDTH)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (slot_load[k]),
                .load_data (IN_DATA),
                .out_ready (slot_ready[k]),
                .valid     (slot_valid[k]),
                .data      (slot_data[k])
            );
        end
    endgenerate

    assign A_VALID = slot_valid[CH_A];
    assign B_VALID = slot_valid[CH_B];
    assign C_VALID = slot_valid[CH_C];
    assign D_VALID = slot_valid[CH_D];

    assign A = slot_data[int'(CH_A)];
    assign B = slot_data[int'(CH_B)];
    assign C = slot_data[int'(CH_C)];
    assign D = slot_data[int'(CH_D)];

    // Pure OR of the slot flops: no input reaches BUSY combinationally.
    assign BUSY = |slot_valid;

`ifndef SYNTHESIS
    // An unknown destination while a beat is offered is a producer bug.
    a_sel_known : assert property (@(posedge clk) disable iff (rst)
        IN_VALID |-> !$isunknown(SEL));
`endif

endmodule : one_to_four_demux_buf
`default_nettype wire

// File: tb/tb_one_to_four_demux_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_one_to_four_demux_buf
//  Purpose  : Self-checking bench for one_to_four_demux_buf (WIDTH = 8).
//             A per-channel queue model predicts IN_READY, every slot's
//             valid/payload and BUSY each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_one_to_four_demux_buf;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;
    logic [1:0]       SEL;
    logic             A_VALID, B_VALID, C_VALID, D_VALID;
    logic             A_READY, B_READY, C_READY, D_READY;
    logic [WIDTH-1:0] A, B, C, D;
    logic             BUSY;

    one_to_four_demux_buf #(
        .WIDTH    (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_DATA  (IN_DATA),
        .SEL      (SEL),
        .A_VALID  (A_VALID),
        .B_VALID  (B_VALID),
        .C_VALID  (C_VALID),
        .D_VALID  (D_VALID),
        .A_READY  (A_READY),
        .B_READY  (B_READY),
        .C_READY  (C_READY),
        .D_READY  (D_READY),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .BUSY     (BUSY)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each channel is a queue of beats waiting for its consumer (capacity 1).
    // last_val is what the channel output shows when nothing is queued.
    logic [WIDTH-1:0] chq [4][$];
    logic [WIDTH-1:0] last_val [4];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               model_deliv = 0;
    int               dut_deliv   = 0;
    bit               last_acc    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [WIDTH-1:0] dut_data(input int k);
        case (k)
            0:       return A;
            1:       return B;
            2:       return C;
            default: return D;
        endcase
    endfunction

    // One clock: drive at negedge, compare just after, update model at posedge.
    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic [WIDTH-1:0] d, input logic [3:0] rdy,
                        input bit chk = 1'b1);
        logic [3:0] dv;
        logic       exp_ready;
        logic [WIDTH-1:0] exp_d;
        @(negedge clk);
        rst = r; IN_VALID = v; SEL = s; IN_DATA = d;
        {D_READY, C_READY, B_READY, A_READY} = rdy;
        #1;
        exp_ready = !r && !(chq[s].size() > 0 && !rdy[s]);
        dv = {D_VALID, C_VALID, B_VALID, A_VALID};
        if (chk) begin
            check("in_ready", 32'(IN_READY), 32'(exp_ready));
            for (int k = 0; k < 4; k++) begin
                exp_d = (chq[k].size() > 0) ? chq[k][0] : last_val[k];
                check($sformatf("valid_%0d", k), 32'(dv[k]), 32'(chq[k].size() > 0));
                check($sformatf("data_%0d", k), 32'(dut_data(k)), 32'(exp_d));
                if (dv[k] && rdy[k] && !r) dut_deliv++;
            end
            check("busy", 32'(BUSY),
                  32'((chq[0].size() + chq[1].size() + chq[2].size() + chq[3].size()) > 0));
        end
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                chq[k].delete();
                last_val[k] = '0;
            end
            last_acc = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (chq[k].size() > 0 && rdy[k]) begin
                    last_val[k] = chq[k].pop_front();
                    if (chk) model_deliv++;
                end
            end
            last_acc = v && exp_ready;
            if (last_acc) begin
                chq[s].push_back(d);
                last_val[s] = d;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic             pv;
        logic [1:0]       ps;
        logic [WIDTH-1:0] pd;
        logic             pr;
        for (int k = 0; k < 4; k++) last_val[k] = '0;

        // Reset with a beat offered; first cycle unchecked (pre-reset state).
        step(1, 1, 2'd0, 8'hAA, 4'hF, 1'b0);
        step(1, 1, 2'd0, 8'hAA, 4'hF);
        step(1, 1, 2'd1, 8'hBB, 4'hF);
        step(0, 0, 2'd0, 8'h00, 4'hF);
        step(0, 0, 2'd0, 8'h00, 4'hF);

        // Basic routing, all consumers ready.
        step(0, 1, 2'd0, 8'h11, 4'hF);
        step(0, 1, 2'd1, 8'h22, 4'hF);
        step(0, 1, 2'd2, 8'h33, 4'hF);
        step(0, 1, 2'd3, 8'h44, 4'hF);
        step(0, 0, 2'd0, 8'h00, 4'hF);
        step(0, 0, 2'd0, 8'h00, 4'hF);

        // Backpressure on B, then simultaneous drain and fill.
        step(0, 1, 2'd1, 8'h5A, 4'b1101);
        step(0, 1, 2'd1, 8'h6B, 4'b1101);
        step(0, 1, 2'd1, 8'h6B, 4'b1101);
        step(0, 1, 2'd1, 8'h6B, 4'b1111);
        step(0, 0, 2'd1, 8'h00, 4'b1101);
        step(0, 0, 2'd1, 8'h00, 4'b1111);
        step(0, 0, 2'd0, 8'h00, 4'hF);

        // Independence: C stalled, D still flows.
        step(0, 1, 2'd2, 8'h77, 4'b1011);
        step(0, 1, 2'd3, 8'h88, 4'b1011);
        step(0, 0, 2'd0, 8'h00, 4'b0011);
        step(0, 0, 2'd0, 8'h00, 4'b1011);
        step(0, 0, 2'd0, 8'h00, 4'hF);
        step(0, 0, 2'd0, 8'h00, 4'hF);

        // Reset mid-operation drops all four held beats.
        step(0, 1, 2'd0, 8'hA1, 4'h0);
        step(0, 1, 2'd1, 8'hB2, 4'h0);
        step(0, 1, 2'd2, 8'hC3, 4'h0);
        step(0, 1, 2'd3, 8'hD4, 4'h0);
        step(0, 0, 2'd0, 8'h00, 4'h0);
        step(1, 0, 2'd0, 8'h00, 4'h0);
        step(0, 0, 2'd0, 8'h00, 4'hF);
        step(0, 0, 2'd0, 8'h00, 4'hF);

        // Random soak; producer holds a beat until the model says accepted.
        pv = 1'b0; ps = '0; pd = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!(pv && !last_acc)) begin
                pv = ($urandom_range(0, 3) != 0);
                ps = 2'($urandom_range(0, 3));
                pd = 8'($urandom);
            end
            pr = ($urandom_range(0, 999) == 0);
            step(pr, pv, ps, pd, 4'($urandom));
            if (pr) pv = 1'b0;
        end
        step(0, 0, 2'd0, 8'h00, 4'hF);

        check("delivered", 32'(dut_deliv), 32'(model_deliv));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_one_to_four_demux_buf
`default_nettype wire

// File: doc/one_to_four_demux_buf.md
Name: one_to_four_demux_buf

Overview:
Registered 1-to-4 demultiplexer for the processor datapath. It steers one producer stream to one of four consumer channels, selected by a 2-bit SEL sent with each beat. Each output has a one-entry holding slot with valid/ready handshake, so a stalled consumer blocks only beats addressed to it. It does the opposite job of the 4-to-1 select mux used on the operand/writeback paths: one source fanned out to four sinks.

Parameters:
WIDTH, 1, data width of the input beat and of each output channel.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
IN_VALID  input  1  producer has a beat
IN_READY  output  1  block accepts the beat this cycle
IN_DATA  input  WIDTH  beat payload
SEL  input  2  destination channel, 0..3, sampled with IN_DATA
A_VALID, B_VALID, C_VALID, D_VALID  output  1 each  slot 0..3 holds a beat
A_READY, B_READY, C_READY, D_READY  input  1 each  consumer 0..3 takes the beat
A, B, C, D  output  WIDTH each  slot 0..3 payload
BUSY  output  1  OR of all four *_VALID

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high. All state changes on the rising edge of clk.
- Reset: all *_VALID = 0, A/B/C/D = {WIDTH{1'b0}}, BUSY = 0. Reset mid-operation drops slot contents; no beat survives reset. While rst = 1, IN_READY is 0.
- Slot k takes a beat when IN_VALID && IN_READY && SEL == k. The slot updates on the next edge, so the beat is visible on the output 1 cycle after acceptance.
- IN_READY = !rst && (!VALID[SEL] || READY[SEL]).
  - This is a combinational path from the selected consumer's READY to IN_READY, and it is intentional.
  - IN_READY must not depend on IN_VALID.
  - IN_READY is a function only of SEL, the selected slot, and the selected consumer's READY.
- Slot k drains when VALID[k] && READY[k]. VALID[k] clears on the next edge unless a new beat is accepted into slot k in the same cycle.
- Same-cycle drain and fill of one slot: VALID stays 1 and the payload is replaced by the new IN_DATA. No bubble and no loss.
- Fill of slot j together with drain of slot k (j != k): both happen independently.
- Holding: while VALID[k] && !READY[k], payload k and VALID[k] stay stable. This is AXI-style: once asserted, VALID is not withdrawn before the handshake completes.
- Payload when VALID[k] = 0: holds the last value. Consumers must not sample it.
- No reordering within one channel; each slot holds one entry. Beats to different channels may complete in any relative order.
- Blocked destination: the producer keeps IN_VALID/IN_DATA/SEL stable until IN_READY. The block does not look past a blocked beat to reach other channels (no head-of-line bypass).
- BUSY is registered-equivalent: the OR of the slot valid flops, with no combinational input path.
- Arithmetic: none. SEL is a full 2-bit decode, so no illegal value exists. An X on SEL while IN_VALID = 1 is a protocol violation and is flagged by a simulation assertion.

Decomposition:
- Shared package: constants NUM_OUT = 4 and SEL_W = 2, and channel index enum CH_A = 0, CH_B = 1, CH_C = 2, CH_D = 3. The existing 4-to-1 mux reuses these.
- One natural sub-module: demux_slot, a WIDTH-parameterised one-entry register.
  - Inputs: load, load_data, out_ready. Outputs: valid, data.
  - Implements the fill/drain/simultaneous rules.
  - Instantiated four times.
- The top level holds the SEL decode, the IN_READY mux and the BUSY OR.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with IN_VALID = 1 → IN_READY = 0, all *_VALID = 0, all outputs 0, BUSY = 0. Release with everything idle → state unchanged.
- Basic routing, WIDTH = 8, all READY = 1: send 8'h11/SEL 0, 8'h22/SEL 1, 8'h33/SEL 2, 8'h44/SEL 3 on consecutive cycles → A = 8'h11 with A_VALID one cycle after acceptance, then B = 8'h22, C = 8'h33, D = 8'h44, each valid for exactly 1 cycle. IN_READY stays 1 throughout.
- Backpressure: B_READY = 0, send 8'h5A/SEL 1 then 8'h6B/SEL 1.
  - First beat is accepted; B = 8'h5A is held.
  - Second beat sees IN_READY = 0 until B_READY = 1.
  - In that cycle the second beat is accepted and drain happens together: B_VALID stays 1 and B becomes 8'h6B next cycle.
- Independence: C_READY = 0 with C holding 8'h77; send 8'h88/SEL 3 → accepted immediately and D = 8'h88. C stays 8'h77 with C_VALID = 1; BUSY = 1 until both drain.
- Reset mid-operation: fill all four slots with all READY = 0, then pulse rst for 1 cycle → all *_VALID = 0 and BUSY = 0 next cycle. Releasing READY afterwards produces no stale beats.
- Random soak (10k cycles, random IN_VALID/SEL/READY): a scoreboard per channel checks in-order, lossless, non-duplicated delivery, VALID/payload stability under stall, and the 1-cycle latency bound.
